// File: rtl/lfsr_pkg.sv
// lfsr_pkg
//   Shared definitions for the LFSR random scheduler: word width, feedback tap
//   positions, substitute seed, lock-up value, scheduler FSM states and the
//   single-step next-state function of the LFSR.
package lfsr_pkg;

    localparam int NUM_BITS = 25;
    localparam int TAP_HI   = NUM_BITS - 1;
    localparam int TAP_LO   = NUM_BITS - 4;

    localparam logic [NUM_BITS-1:0] LFSR_DEFAULT_SEED = 25'h00ACE1;
    // XNOR feedback makes all-ones the one state that maps onto itself.
    localparam logic [NUM_BITS-1:0] LFSR_LOCKUP       = {NUM_BITS{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_SERVE  = 2'd2
    } sched_state_e;

    function automatic logic [NUM_BITS-1:0] lfsr_step(input logic [NUM_BITS-1:0] s);
        return {s[NUM_BITS-2:0], ~(s[TAP_HI] ^ s[TAP_LO])};
    endfunction

endpackage

// File: rtl/lfsr_step_core.sv
// lfsr_step_core
//   LFSR state register with load / step / hold control and a lock-up guard.
//   Priority: reset, load, lock-up recovery, step, hold.
// Ports
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset, state returns to SUBST_SEED
//   i_load      load i_load_val this cycle
//   i_load_val  value to load (caller has already replaced the lock-up value)
//   i_step      advance the LFSR by one step
//   i_guard     lock-up recovery enabled (scheduler is warming up or serving)
//   o_state     current LFSR state
module lfsr_step_core
    import lfsr_pkg::*;
#(
    parameter logic [NUM_BITS-1:0] SUBST_SEED = LFSR_DEFAULT_SEED
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_load,
    input  logic [NUM_BITS-1:0] i_load_val,
    input  logic                i_step,
    input  logic                i_guard,
    output logic [NUM_BITS-1:0] o_state
);

    logic [NUM_BITS-1:0] state_r;
    logic [NUM_BITS-1:0] state_nxt_s;

    // Next-state selection for the LFSR register.
    always_comb begin
        state_nxt_s = state_r;
        if (i_load) begin
            state_nxt_s = i_load_val;
        end else if (i_guard && (state_r == LFSR_LOCKUP)) begin
            state_nxt_s = SUBST_SEED;
        end else if (i_step) begin
            state_nxt_s = lfsr_step(state_r);
        end else begin
            state_nxt_s = state_r;
        end
    end

    // LFSR state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= SUBST_SEED;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    assign o_state = state_r;

endmodule

// File: rtl/lfsr_rand_scheduler.sv
// lfsr_rand_scheduler
//   Shares one LFSR among NUM_REQ requesters. A seed load restarts the LFSR,
//   steps it WARMUP times, then serves requests round-robin, one random word
//   per grant (the LFSR value at the decision cycle), one cycle after request.
// Ports
//   i_clk         clock, rising edge
//   i_rst         synchronous active-high reset, highest priority
//   i_seed_load   load i_seed (sampled every cycle, wins over requests)
//   i_seed        seed value; all-ones is replaced by DEFAULT_SEED
//   i_req         per-requester request, held until granted
//   o_ready       1 while in SERVE
//   o_grant       registered one-hot grant, one cycle wide
//   o_rand_valid  o_rand_data carries a fresh word (== |o_grant)
//   o_rand_data   random word for the granted requester, holds otherwise
//   o_draw_cnt    grants since last seed load, wraps
module lfsr_rand_scheduler
    import lfsr_pkg::*;
#(
    parameter int                  NUM_REQ      = 4,
    parameter int                  WARMUP       = 16,
    parameter logic [NUM_BITS-1:0] DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_seed_load,
    input  logic [NUM_BITS-1:0] i_seed,
    input  logic [NUM_REQ-1:0]  i_req,
    output logic                o_ready,
    output logic [NUM_REQ-1:0]  o_grant,
    output logic                o_rand_valid,
    output logic [NUM_BITS-1:0] o_rand_data,
    output logic [15:0]         o_draw_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WU_W  = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]   PTR_MOD  = (PTR_W+1)'(NUM_REQ);
    localparam logic [WU_W-1:0]  WU_INIT  = WU_W'(WARMUP);

    sched_state_e        state_r;
    logic [WU_W-1:0]     wu_cnt_r;
    logic [PTR_W-1:0]    ptr_r;
    logic                ready_r;
    logic [NUM_REQ-1:0]  grant_r;
    logic                valid_r;
    logic [NUM_BITS-1:0] data_r;
    logic [15:0]         draw_cnt_r;

    logic [NUM_BITS-1:0] lfsr_state_s;
    logic [NUM_BITS-1:0] load_val_s;
    logic                serve_pick_s;
    logic                step_s;
    logic                guard_s;

    logic [PTR_W:0]      cand_s;
    logic [PTR_W-1:0]    cand_idx_s;
    logic                pick_vld_s;
    logic [PTR_W-1:0]    pick_idx_s;
    logic [PTR_W-1:0]    ptr_nxt_s;
    logic [NUM_REQ-1:0]  onehot_s;

    // Round-robin search: first request at or above ptr_r, wrapping. The loop
    // runs from the farthest candidate down so the nearest one wins.
    always_comb begin
        pick_vld_s = 1'b0;
        pick_idx_s = '0;
        cand_s     = '0;
        cand_idx_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_s = {1'b0, ptr_r} + (PTR_W+1)'(k);
            if (cand_s >= PTR_MOD) begin
                cand_s = cand_s - PTR_MOD;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = cand_s[PTR_W-1:0];
            if (i_req[cand_idx_s]) begin
                pick_vld_s = 1'b1;
                pick_idx_s = cand_idx_s;
            end else begin
                pick_vld_s = pick_vld_s;
                pick_idx_s = pick_idx_s;
            end
        end
    end

    // Grant vector and pointer advance for the selected requester.
    always_comb begin
        onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
        if (pick_idx_s == PTR_LAST) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = pick_idx_s + PTR_W'(1);
        end
    end

    // LFSR control decode; a seed load always beats stepping and serving.
    always_comb begin
        load_val_s   = (i_seed == LFSR_LOCKUP) ? DEFAULT_SEED : i_seed;
        serve_pick_s = (state_r == ST_SERVE) && !i_seed_load && pick_vld_s;
        guard_s      = (state_r != ST_IDLE);
        if (i_seed_load) begin
            step_s = 1'b0;
        end else if ((state_r == ST_WARMUP) && (wu_cnt_r != '0)) begin
            step_s = 1'b1;
        end else begin
            step_s = serve_pick_s;
        end
    end

    lfsr_step_core #(
        .SUBST_SEED (DEFAULT_SEED)
    ) u_core (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (i_seed_load),
        .i_load_val (load_val_s),
        .i_step     (step_s),
        .i_guard    (guard_s),
        .o_state    (lfsr_state_s)
    );

    // Scheduler FSM with warm-up counter, RR pointer and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            wu_cnt_r   <= '0;
            ptr_r      <= '0;
            ready_r    <= 1'b0;
            grant_r    <= '0;
            valid_r    <= 1'b0;
            data_r     <= '0;
            draw_cnt_r <= 16'd0;
        end else if (i_seed_load) begin
            state_r    <= ST_WARMUP;
            wu_cnt_r   <= WU_INIT;
            ptr_r      <= '0;
            ready_r    <= 1'b0;
            grant_r    <= '0;
            valid_r    <= 1'b0;
            draw_cnt_r <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ready_r <= 1'b0;
                    grant_r <= '0;
                    valid_r <= 1'b0;
                end
                ST_WARMUP: begin
                    grant_r <= '0;
                    valid_r <= 1'b0;
                    if (wu_cnt_r == '0) begin
                        state_r <= ST_SERVE;
                        ready_r <= 1'b1;
                    end else begin
                        wu_cnt_r <= wu_cnt_r - WU_W'(1);
                        ready_r  <= 1'b0;
                    end
                end
                ST_SERVE: begin
                    ready_r <= 1'b1;
                    if (serve_pick_s) begin
                        grant_r    <= onehot_s;
                        valid_r    <= 1'b1;
                        data_r     <= lfsr_state_s;
                        ptr_r      <= ptr_nxt_s;
                        draw_cnt_r <= draw_cnt_r + 16'd1;
                    end else begin
                        grant_r <= '0;
                        valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                    grant_r <= '0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready      = ready_r;
    assign o_grant      = grant_r;
    assign o_rand_valid = valid_r;
    assign o_rand_data  = data_r;
    assign o_draw_cnt   = draw_cnt_r;

endmodule

// File: tb/tb_lfsr_rand_scheduler.sv
// tb_lfsr_rand_scheduler
//   Drives two scheduler instances (WARMUP=0 and WARMUP=16) from shared inputs
//   and compares every output each cycle against a behavioural model, plus
//   directed checks of the documented example values.
module tb_lfsr_rand_scheduler;

    localparam logic [24:0] DEF  = 25'h00ACE1;
    localparam logic [24:0] ALL1 = 25'h1FFFFFF;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_seed_load = 1'b0;
    logic [24:0] i_seed = 25'd0;
    logic [3:0]  i_req = 4'd0;

    logic        rdy [2];
    logic [3:0]  gnt [2];
    logic        vld [2];
    logic [24:0] dat [2];
    logic [15:0] cnt [2];

    always #5 i_clk = ~i_clk;

    lfsr_rand_scheduler #(.NUM_REQ(4), .WARMUP(0), .DEFAULT_SEED(25'h00ACE1)) dut0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_seed_load(i_seed_load), .i_seed(i_seed),
        .i_req(i_req), .o_ready(rdy[0]), .o_grant(gnt[0]), .o_rand_valid(vld[0]),
        .o_rand_data(dat[0]), .o_draw_cnt(cnt[0]));

    lfsr_rand_scheduler #(.NUM_REQ(4), .WARMUP(16), .DEFAULT_SEED(25'h00ACE1)) dut16 (
        .i_clk(i_clk), .i_rst(i_rst), .i_seed_load(i_seed_load), .i_seed(i_seed),
        .i_req(i_req), .o_ready(rdy[1]), .o_grant(gnt[1]), .o_rand_valid(vld[1]),
        .o_rand_data(dat[1]), .o_draw_cnt(cnt[1]));

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Behavioural model state, one entry per instance.
    int          m_mode [2];     // 0 idle, 1 warming, 2 serving
    int          m_serve_at [2]; // edge number on which serving begins
    int          m_ptr [2];
    logic [24:0] m_lfsr [2];
    logic        m_ready [2];
    logic [3:0]  m_grant [2];
    logic        m_valid [2];
    logic [24:0] m_data [2];
    logic [15:0] m_cnt [2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [24:0] next_rand(input logic [24:0] s);
        logic fb;
        fb = ~(s[24] ^ s[21]);
        return ((s << 1) & ALL1) | {24'd0, fb};
    endfunction

    task automatic model_edge(input int i, input logic rst, input logic load,
                              input logic [24:0] seed, input logic [3:0] req);
        int warm;
        int sel;
        logic [24:0] l;
        warm = (i == 0) ? 0 : 16;
        if (rst) begin
            m_mode[i] = 0; m_ptr[i] = 0; m_lfsr[i] = DEF; m_ready[i] = 1'b0;
            m_grant[i] = 4'd0; m_valid[i] = 1'b0; m_data[i] = 25'd0; m_cnt[i] = 16'd0;
        end else if (load) begin
            l = (seed == ALL1) ? DEF : seed;
            for (int k = 0; k < warm; k++) l = next_rand(l);
            m_lfsr[i] = l;
            m_serve_at[i] = cyc + warm + 1;
            m_mode[i] = 1; m_ptr[i] = 0; m_cnt[i] = 16'd0;
            m_ready[i] = 1'b0; m_grant[i] = 4'd0; m_valid[i] = 1'b0;
        end else if (m_mode[i] == 1) begin
            m_grant[i] = 4'd0; m_valid[i] = 1'b0;
            if (cyc >= m_serve_at[i]) begin
                m_mode[i] = 2;
                m_ready[i] = 1'b1;
            end
        end else if (m_mode[i] == 2) begin
            m_ready[i] = 1'b1;
            sel = -1;
            for (int k = 0; k < 4; k++)
                if (sel < 0 && req[(m_ptr[i] + k) % 4]) sel = (m_ptr[i] + k) % 4;
            if (sel >= 0) begin
                m_grant[i] = 4'(1 << sel);
                m_valid[i] = 1'b1;
                m_data[i]  = m_lfsr[i];
                m_lfsr[i]  = next_rand(m_lfsr[i]);
                m_ptr[i]   = (sel + 1) % 4;
                m_cnt[i]   = m_cnt[i] + 16'd1;
            end else begin
                m_grant[i] = 4'd0;
                m_valid[i] = 1'b0;
            end
        end else begin
            m_ready[i] = 1'b0; m_grant[i] = 4'd0; m_valid[i] = 1'b0;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("ready%0d", i), {31'd0, rdy[i]}, {31'd0, m_ready[i]});
            check_eq($sformatf("grant%0d", i), {28'd0, gnt[i]}, {28'd0, m_grant[i]});
            check_eq($sformatf("valid%0d", i), {31'd0, vld[i]}, {31'd0, m_valid[i]});
            check_eq($sformatf("data%0d", i), {7'd0, dat[i]}, {7'd0, m_data[i]});
            check_eq($sformatf("drawcnt%0d", i), {16'd0, cnt[i]}, {16'd0, m_cnt[i]});
            if (vld[i]) check_eq($sformatf("no_lockup%0d", i), {31'd0, (dat[i] == ALL1)}, 32'd0);
        end
    endtask

    task automatic apply(input logic rst, input logic load, input logic [24:0] seed,
                         input logic [3:0] req);
        i_rst = rst; i_seed_load = load; i_seed = seed; i_req = req;
        @(posedge i_clk);
        cyc++;
        for (int i = 0; i < 2; i++) model_edge(i, rst, load, seed, req);
        #1;
        compare_all();
    endtask

    logic [24:0] t1_data [3];
    logic [3:0]  t2_grant [5];
    logic [24:0] rseed;

    initial begin
        t1_data  = '{25'h1, 25'h3, 25'h7};
        t2_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset state.
        apply(1'b1, 1'b0, 25'd0, 4'd0);
        apply(1'b1, 1'b0, 25'd0, 4'd0);
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_ready", {31'd0, rdy[i]}, 32'd0);
            check_eq("rst_data", {7'd0, dat[i]}, 32'd0);
        end

        // Seed 1, single requester 0, three grants.
        apply(1'b0, 1'b1, 25'h1, 4'd0);
        apply(1'b0, 1'b0, 25'h0, 4'b0001);
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 1'b0, 25'h0, 4'b0001);
            check_eq("t1_grant", {28'd0, gnt[0]}, 32'b0001);
            check_eq("t1_data", {7'd0, dat[0]}, {7'd0, t1_data[k]});
        end
        check_eq("t1_drawcnt", {16'd0, cnt[0]}, 32'd3);

        // All four requesting: strict rotation from requester 0.
        apply(1'b0, 1'b1, 25'h0ABC, 4'd0);
        apply(1'b0, 1'b0, 25'h0, 4'd0);
        for (int k = 0; k < 5; k++) begin
            apply(1'b0, 1'b0, 25'h0, 4'b1111);
            check_eq("t2_grant", {28'd0, gnt[0]}, {28'd0, t2_grant[k]});
            check_eq("t2_valid", {31'd0, vld[0]}, 32'd1);
        end

        // Lock-up seed substituted.
        apply(1'b0, 1'b1, ALL1, 4'd0);
        apply(1'b0, 1'b0, 25'h0, 4'd0);
        apply(1'b0, 1'b0, 25'h0, 4'b0100);
        check_eq("t3_grant", {28'd0, gnt[0]}, 32'b0100);
        check_eq("t3_data", {7'd0, dat[0]}, {7'd0, DEF});

        // Seed load beats requests; warm-up of 16 on the second instance.
        apply(1'b0, 1'b0, 25'h0, 4'd0);
        apply(1'b0, 1'b1, 25'h1234, 4'b0011);
        check_eq("t4_nogrant", {28'd0, gnt[0]}, 32'd0);
        check_eq("t4_drawcnt", {16'd0, cnt[0]}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            apply(1'b0, 1'b0, 25'h0, 4'b0011);
            check_eq("t4_warm_ready", {31'd0, rdy[1]}, 32'd0);
            check_eq("t4_warm_grant", {28'd0, gnt[1]}, 32'd0);
        end
        apply(1'b0, 1'b0, 25'h0, 4'b0011);
        check_eq("t4_ready", {31'd0, rdy[1]}, 32'd1);
        apply(1'b0, 1'b0, 25'h0, 4'b0011);
        check_eq("t4_grant", {28'd0, gnt[1]}, 32'b0001);
        check_eq("t4_drawcnt_after", {16'd0, cnt[1]}, 32'd1);

        // Reset in the middle of warm-up, together with a seed load.
        apply(1'b0, 1'b1, 25'h5555, 4'b1111);
        for (int k = 0; k < 5; k++) apply(1'b0, 1'b0, 25'h0, 4'b1111);
        apply(1'b1, 1'b1, 25'h7777, 4'b1111);
        for (int i = 0; i < 2; i++) begin
            check_eq("t5_rst_ready", {31'd0, rdy[i]}, 32'd0);
            check_eq("t5_rst_grant", {28'd0, gnt[i]}, 32'd0);
            check_eq("t5_rst_valid", {31'd0, vld[i]}, 32'd0);
            check_eq("t5_rst_data", {7'd0, dat[i]}, 32'd0);
            check_eq("t5_rst_drawcnt", {16'd0, cnt[i]}, 32'd0);
        end
        for (int k = 0; k < 20; k++) begin
            apply(1'b0, 1'b0, 25'h0, 4'b1111);
            check_eq("t5_idle_valid", {31'd0, vld[1]}, 32'd0);
        end

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            rseed = ($urandom_range(7) == 0) ? ALL1 : 25'($urandom);
            apply(($urandom_range(199) == 0), ($urandom_range(39) == 0), rseed, 4'($urandom));
        end

        // Draw-counter wrap after 65536 back-to-back grants.
        rseed = 25'($urandom);
        apply(1'b0, 1'b1, rseed, 4'd0);
        for (int k = 0; k < 65537; k++) apply(1'b0, 1'b0, 25'h0, 4'($urandom_range(15, 1)));
        check_eq("t6_wrap", {16'd0, cnt[0]}, 32'd0);
        check_eq("t6_valid", {31'd0, vld[0]}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
